mc_addsub_ctrl: RTL and testbench

- Word-serial controller that runs K-bit add/subtract on one W-bit carry-lookahead adder slice, one slice operation per accepted word.
- Operands stream in LSW first. The inter-word carry is held in a register between words, and result words stream out with valid/ready backpressure.
- Sits between the operand buffers and the Montgomery datapath. Its job is the big-number add and the conditional final subtraction.

---
 rtl/mc_addsub_ctrl.sv | 122 ++++++++++++
 tb/tb_mc_addsub_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_addsub_ctrl.sv
// Word-serial K-bit add/subtract controller around one W-bit carry-lookahead slice.
// Operands arrive LSW first; the inter-word carry is held between accepted words.
module mc_addsub_ctrl #(
    parameter int K = 4096,
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_sub,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_last,
    output logic         out_co,
    output logic         busy
);
    localparam int N  = K / W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          sub_r;
    logic [W-1:0]  sum_n;
    logic          co_n;
    logic          in_accept;
    logic          cnt_last;

    // Single output register that can be refilled in the same cycle it is drained.
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign in_accept = in_valid && in_ready;
    assign cnt_last  = (cnt == CW'(N - 1));

    // 4-bit lookahead groups, group carries chained across the slice.
    always_comb begin : slice
        logic [W-1:0] b_x;
        logic [3:0]   g;
        logic [3:0]   p;
        logic [3:0]   cv;
        logic         c;
        // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
        b_x   = in_b ^ {W{sub_r}};
        sum_n = '0;
        g     = '0;
        p     = '0;
        cv    = '0;
        c     = carry;
        for (int gi = 0; gi < W / 4; gi++) begin
            g     = in_a[4*gi +: 4] & b_x[4*gi +: 4];
            p     = in_a[4*gi +: 4] ^ b_x[4*gi +: 4];
            cv[0] = c;
            cv[1] = g[0] | (p[0] & c);
            cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
            cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
            sum_n[4*gi +: 4] = p ^ cv;
            c = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (&p & c);
        end
        co_n = c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            sub_r     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_co    <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every read sees the pre-edge value.
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        sub_r     <= cmd_sub;
                        carry     <= cmd_sub;
                        cnt       <= '0;
                        state     <= RUN;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (in_accept) begin
                        out_sum   <= sum_n;
                        carry     <= co_n;
                        out_valid <= 1'b1;
                        out_last  <= cnt_last;
                        out_co    <= cnt_last ? co_n : 1'b0;
                        cnt       <= cnt_last ? '0 : cnt + CW'(1);
                        if (cnt_last) state <= DRAIN;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_addsub_ctrl.sv
// Scoreboard bench for mc_addsub_ctrl: three configurations (K16/W4, default, N=1)
// share one stimulus path selected by sel; expectations come from whole-number arithmetic.
module tb_mc_addsub_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_sub = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [255:0] in_a = '0;
    logic [255:0] in_b = '0;
    int           sel = 0;

    logic [2:0]   cr, ir, ov, ol, oc, bz;
    logic [3:0]   s0;
    logic [255:0] s1, s2;

    logic         cmd_ready_m, in_ready_m, out_valid_m, out_last_m, out_co_m, busy_m;
    logic [255:0] sum_m;

    int wtab [3] = '{4, 256, 256};
    int ntab [3] = '{4, 16, 1};

    typedef struct {
        logic [255:0] sum;
        logic         last;
        logic         co;
        int           idx;
    } exp_t;

    exp_t q[$];
    int   spans[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    bit   mon_en = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mc_addsub_ctrl #(.K(16), .W(4)) u_small (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && sel == 0), .cmd_ready(cr[0]),
        .cmd_sub(cmd_sub), .in_valid(in_valid && sel == 0), .in_ready(ir[0]),
        .in_a(in_a[3:0]), .in_b(in_b[3:0]), .out_valid(ov[0]), .out_ready(out_ready),
        .out_sum(s0), .out_last(ol[0]), .out_co(oc[0]), .busy(bz[0]));

    mc_addsub_ctrl u_dflt (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && sel == 1), .cmd_ready(cr[1]),
        .cmd_sub(cmd_sub), .in_valid(in_valid && sel == 1), .in_ready(ir[1]),
        .in_a(in_a), .in_b(in_b), .out_valid(ov[1]), .out_ready(out_ready),
        .out_sum(s1), .out_last(ol[1]), .out_co(oc[1]), .busy(bz[1]));

    mc_addsub_ctrl #(.K(256), .W(256)) u_one (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && sel == 2), .cmd_ready(cr[2]),
        .cmd_sub(cmd_sub), .in_valid(in_valid && sel == 2), .in_ready(ir[2]),
        .in_a(in_a), .in_b(in_b), .out_valid(ov[2]), .out_ready(out_ready),
        .out_sum(s2), .out_last(ol[2]), .out_co(oc[2]), .busy(bz[2]));

    always_comb begin
        cmd_ready_m = cr[sel];
        in_ready_m  = ir[sel];
        out_valid_m = ov[sel];
        out_last_m  = ol[sel];
        out_co_m    = oc[sel];
        busy_m      = bz[sel];
        case (sel)
            0:       sum_m = {252'b0, s0};
            1:       sum_m = s1;
            default: sum_m = s2;
        endcase
    end

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // A beat seen valid&ready at the negedge is consumed on the following posedge.
    always @(negedge clk) begin
        if (mon_en && !rst && out_valid_m && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_beat", 256'(q.size()), 256'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("sum[%0d]", e.idx), sum_m, e.sum);
                check($sformatf("last[%0d]", e.idx), 256'(out_last_m), 256'(e.last));
                if (e.last) check("out_co", 256'(out_co_m), 256'(e.co));
                if (e.idx == 0) first_cyc = cyc;
                if (e.last) spans.push_back(cyc - first_cyc);
            end
        end
    end

    task automatic issue_cmd(input logic sub);
        bit ok = 1'b0;
        cmd_sub   = sub;
        cmd_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (cmd_ready_m) begin
                ok = 1'b1;
                check("cmd_in_idle", 256'(busy_m), 256'd0);
            end
        end
        if (!ok) check("cmd_timeout", 256'(cmd_ready_m), 256'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic feed_word(input logic [255:0] a, input logic [255:0] b);
        bit ok = 1'b0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready_m) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) check("in_timeout", 256'(in_ready_m), 256'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_op(input logic sub, input logic [4095:0] a, input logic [4095:0] b,
                           input bit gaps);
        int w = wtab[sel];
        int n = ntab[sel];
        int kk = w * n;
        logic [4095:0] kmask, bx;
        logic [4096:0] res;
        logic [255:0]  wmask;
        exp_t e;
        kmask = '1;
        kmask = kmask >> (4096 - kk);
        wmask = '1;
        wmask = wmask >> (256 - w);
        bx    = (sub ? ~b : b) & kmask;
        res   = {1'b0, a & kmask} + {1'b0, bx} + 4097'(sub);
        for (int i = 0; i < n; i++) begin
            e.sum  = 256'(res >> (i * w)) & wmask;
            e.last = (i == n - 1);
            e.co   = res[kk];
            e.idx  = i;
            q.push_back(e);
        end
        issue_cmd(sub);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 feed_word(256'(a >> (i * w)) & wmask, 256'(b >> (i * w)) & wmask);
        end
    endtask

    task automatic wait_empty();
        for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
        if (q.size() != 0) check("drain_timeout", 256'(q.size()), 256'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4095:0] ra, rb;

        // Reset state
        #12;
        check("rst_out_valid", 256'(ov), 256'd0);
        check("rst_busy", 256'(bz), 256'd0);
        check("rst_in_ready", 256'(ir), 256'd0);
        check("rst_cmd_ready", 256'(cr), 256'd0);
        check("rst_sum", s1, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("cmd_ready_pre_edge", 256'(cmd_ready_m), 256'd0);
        @(posedge clk);
        #1 check("cmd_ready_post_rst", 256'(cmd_ready_m), 256'd1);

        // Operand words in IDLE are ignored
        in_a = 256'h5; in_b = 256'h3; in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_in_ready", 256'(in_ready_m), 256'd0);
            check("idle_out_valid", 256'(out_valid_m), 256'd0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;

        // 1: K16 add with full carry ripple, then cmd_ready timing
        sel = 0;
        spans.delete();
        send_op(1'b0, 4096'hFFFF, 4096'h0001, 1'b0);
        @(negedge clk); check("cr_after_last_0", 256'(cmd_ready_m), 256'd0);
        @(negedge clk); check("cr_after_last_1", 256'(cmd_ready_m), 256'd0);
        @(negedge clk); check("cr_after_last_2", 256'(cmd_ready_m), 256'd1);
        wait_empty();
        if (spans.size() > 0) check("span_k16", 256'(spans.pop_front()), 256'd3);

        // 2: subtracts; second must not inherit carry; input gaps hold state
        send_op(1'b1, 4096'h1234, 4096'h1234, 1'b0);
        send_op(1'b1, 4096'h0000, 4096'h0001, 1'b1);
        send_op(1'b0, 4096'h8A3C, 4096'h79E5, 1'b1);
        wait_empty();

        // 3: backpressure after the first output
        out_ready = 1'b0;
        fork
            send_op(1'b0, 4096'h00FF, 4096'h0001, 1'b0);
            begin
                for (int t = 0; t < 20 && !out_valid_m; t++) @(negedge clk);
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", 256'(in_ready_m), 256'd0);
                    check("bp_hold_sum", sum_m, 256'd0);
                    check("bp_hold_valid", 256'(out_valid_m), 256'd1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_empty();

        // 4: reset after two accepted words
        mon_en = 1'b0;
        issue_cmd(1'b0);
        feed_word(256'h3, 256'h4);
        feed_word(256'h7, 256'h9);
        check("pre_rst_valid", 256'(out_valid_m), 256'd1);
        rst = 1'b1;
        #1;
        check("async_out_valid", 256'(out_valid_m), 256'd0);
        check("async_busy", 256'(busy_m), 256'd0);
        check("async_out_co", 256'(out_co_m), 256'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", 256'(cmd_ready_m), 256'd1);
        check("post_rst_no_valid", 256'(out_valid_m), 256'd0);
        send_op(1'b0, 4096'h0001, 4096'h0001, 1'b0);
        wait_empty();

        // 5: default config, back-to-back random commands
        sel = 1;
        @(posedge clk);
        #1;
        spans.delete();
        for (int i = 0; i < 128; i++) begin
            ra[i*32 +: 32] = $urandom;
            rb[i*32 +: 32] = $urandom;
        end
        send_op(1'b0, ra, rb, 1'b0);
        send_op(1'b1, rb, ra, 1'b0);
        send_op(1'b0, ra, ~ra, 1'b0);
        wait_empty();
        check("span_cnt", 256'(spans.size()), 256'd3);
        while (spans.size() > 0) check("throughput", 256'(spans.pop_front()), 256'd15);

        // 6: N=1
        sel = 2;
        @(posedge clk);
        #1;
        send_op(1'b0, {3840'b0, {256{1'b1}}}, 4096'h1, 1'b0);
        send_op(1'b1, 4096'h5, 4096'h9, 1'b0);
        wait_empty();

        check("queue_empty", 256'(q.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
